// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame target: oversamples SCK/CS/MOSI on Mclk and decodes
// frames of [address][command][N_BYTES payload]. Command 8'h02 writes the
// payload into Frame_Data; command 8'h03 returns Frame_Data on MISO.
module spi_frame_slave #(
    parameter logic [7:0]  DEV_ADDR    = 8'h5A,
    parameter int unsigned N_BYTES     = 15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   Mclk,
    input  logic                   nReset,
    input  logic                   SPI_clk,
    input  logic                   SPI_CS,
    input  logic                   SPI_MOSI,
    output logic                   SPI_MISO,
    output logic                   SPI_MISO_OE,
    output logic [8*N_BYTES-1:0]   Frame_Data,
    output logic                   Frame_Valid,
    output logic                   Addr_Match,
    output logic                   Frame_Error
);

    localparam int unsigned W      = 8 * N_BYTES;
    localparam int unsigned BYTE_W = $clog2(N_BYTES + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StCmd, StData, StIgnore} state_e;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    state_e                 state_q;
    logic [2:0]             bit_cnt_q;
    logic [BYTE_W-1:0]      byte_cnt_q;
    logic [6:0]             shift_in_q;
    logic [W-2:0]           shadow_q;
    logic [W-1:0]           rd_shift_q;
    logic                   is_read_q;
    logic [7:0]             byte_in;
    logic                   last_bit;
    logic                   partial;

    // Pin synchronisers plus one-cycle delayed copies for edge detection.
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Strobes and decode helpers used by the frame FSM.
    always_comb begin
        sck_s    = sck_sync[SYNC_STAGES-1];
        cs_s     = cs_sync[SYNC_STAGES-1];
        mosi_s   = mosi_sync[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_d;
        sck_fall = ~sck_s & sck_d;
        cs_fall  = cs_d & ~cs_s;
        cs_rise  = ~cs_d & cs_s;
        byte_in  = {shift_in_q, mosi_s};
        last_bit = (bit_cnt_q == 3'd7) && (byte_cnt_q == BYTE_W'(N_BYTES - 1));
        // Any CS rise after bits were clocked but before the payload completed.
        partial  = ((state_q == StAddr) && (bit_cnt_q != 3'd0)) ||
                   (state_q == StCmd) || (state_q == StData);
    end

    // Frame FSM with registered outputs; CS deassertion overrides any SCK strobe.
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_in_q  <= '0;
            shadow_q    <= '0;
            rd_shift_q  <= '0;
            is_read_q   <= 1'b0;
            Frame_Data  <= '0;
            Frame_Valid <= 1'b0;
            Frame_Error <= 1'b0;
            Addr_Match  <= 1'b0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
        end else begin
            Frame_Valid <= 1'b0;
            Frame_Error <= 1'b0;
            if (cs_rise) begin
                state_q     <= StIdle;
                Addr_Match  <= 1'b0;
                SPI_MISO_OE <= 1'b0;
                SPI_MISO    <= 1'b0;
                Frame_Error <= partial;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q    <= StAddr;
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                    StAddr, StCmd: begin
                        if (sck_rise) begin
                            shift_in_q <= byte_in[6:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == StAddr) begin
                                    if (byte_in == DEV_ADDR) begin
                                        Addr_Match <= 1'b1;
                                        state_q    <= StCmd;
                                    end else begin
                                        state_q    <= StIgnore;
                                    end
                                end else if (byte_in == 8'h02) begin
                                    is_read_q  <= 1'b0;
                                    byte_cnt_q <= '0;
                                    state_q    <= StData;
                                end else if (byte_in == 8'h03) begin
                                    is_read_q   <= 1'b1;
                                    byte_cnt_q  <= '0;
                                    rd_shift_q  <= Frame_Data;
                                    SPI_MISO    <= Frame_Data[W-1];
                                    SPI_MISO_OE <= 1'b1;
                                    state_q     <= StData;
                                end else begin
                                    Frame_Error <= 1'b1;
                                    state_q     <= StIgnore;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (sck_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                            end
                            if (is_read_q) begin
                                rd_shift_q <= {rd_shift_q[W-2:0], 1'b0};
                            end else begin
                                shadow_q <= {shadow_q[W-3:0], mosi_s};
                            end
                            if (last_bit) begin
                                if (!is_read_q) begin
                                    Frame_Data  <= {shadow_q, mosi_s};
                                    Frame_Valid <= 1'b1;
                                end
                                SPI_MISO_OE <= 1'b0;
                                state_q     <= StIgnore;
                            end
                        end else if (sck_fall && is_read_q) begin
                            // The shifter advances on rises, so the first fall re-presents the MSB.
                            SPI_MISO <= rd_shift_q[W-1];
                        end
                    end
                    StIgnore: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Self-checking bench for spi_frame_slave: bit-banged mode-0 master at 1 MHz
// SCK against a 50 MHz Mclk, with a scoreboard of expected write frames.
`timescale 1ns/1ps
module tb_spi_frame_slave;

    localparam int W    = 120;
    localparam int HALF = 500;

    logic         Mclk = 1'b0;
    logic         nReset = 1'b0;
    logic         SPI_clk = 1'b0;
    logic         SPI_CS = 1'b1;
    logic         SPI_MOSI = 1'b0;
    logic         SPI_MISO;
    logic         SPI_MISO_OE;
    logic [W-1:0] Frame_Data;
    logic         Frame_Valid;
    logic         Addr_Match;
    logic         Frame_Error;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int error_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rd_exp_q[$];
    logic [7:0]   tx_q[$];
    logic         miso_q[$];
    logic         am_q[$];
    logic         oe_q[$];
    logic         oe_end;
    logic [W-1:0] mon_exp;

    localparam logic [W-1:0] PAY1 = 120'h3FA0BCFADFE3410021BBC9FAE25A1F;

    spi_frame_slave #(
        .DEV_ADDR   (8'h5A),
        .N_BYTES    (15),
        .SYNC_STAGES(2)
    ) dut (
        .Mclk       (Mclk),
        .nReset     (nReset),
        .SPI_clk    (SPI_clk),
        .SPI_CS     (SPI_CS),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_MISO   (SPI_MISO),
        .SPI_MISO_OE(SPI_MISO_OE),
        .Frame_Data (Frame_Data),
        .Frame_Valid(Frame_Valid),
        .Addr_Match (Addr_Match),
        .Frame_Error(Frame_Error)
    );

    always #10 Mclk = ~Mclk;

    // Scoreboard side: every Frame_Valid cycle pops one expected write frame.
    always @(negedge Mclk) begin
        if (Frame_Valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL valid_unexpected: got Frame_Data=%h, no write frame expected",
                         Frame_Data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (Frame_Data !== mon_exp) begin
                    failures++;
                    $display("FAIL valid_data: got %h, expected %h", Frame_Data, mon_exp);
                end
            end
        end
        if (Frame_Error === 1'b1) error_cnt++;
    end

    function automatic int count_ones(input logic q[$], input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi && i < q.size(); i++) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic load_tx(input logic [7:0] addr, input logic [7:0] cmd,
                           input logic [W-1:0] pay, input int nbytes);
        tx_q.delete();
        tx_q.push_back(addr);
        tx_q.push_back(cmd);
        for (int k = 0; k < nbytes; k++) tx_q.push_back(pay[W-1-8*k -: 8]);
    endtask

    // Clock out tx_q as one mode-0 frame, recording MISO/Addr_Match/OE at each SCK rise.
    task automatic spi_frame(input bit release_cs);
        logic [7:0] b;
        miso_q.delete();
        am_q.delete();
        oe_q.delete();
        SPI_CS = 1'b0;
        #HALF;
        foreach (tx_q[k]) begin
            b = tx_q[k];
            for (int i = 7; i >= 0; i--) begin
                SPI_MOSI = b[i];
                #HALF;
                SPI_clk = 1'b1;
                miso_q.push_back(SPI_MISO);
                am_q.push_back(Addr_Match);
                oe_q.push_back(SPI_MISO_OE);
                #HALF;
                SPI_clk = 1'b0;
            end
        end
        #HALF;
        oe_end = SPI_MISO_OE;
        if (release_cs) begin
            SPI_CS = 1'b1;
            #200;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #40 SPI_clk = ~SPI_clk;
        end
        checks++;
        if ({SPI_MISO, SPI_MISO_OE, Frame_Valid, Addr_Match, Frame_Error, Frame_Data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got miso=%b oe=%b fv=%b am=%b fe=%b data=%h, expected all 0",
                     SPI_MISO, SPI_MISO_OE, Frame_Valid, Addr_Match, Frame_Error, Frame_Data);
        end
        nReset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #100 SPI_clk = ~SPI_clk;
        end
        SPI_clk = 1'b0;
        #200;
        checks++;
        if ({SPI_MISO, SPI_MISO_OE, Frame_Valid, Addr_Match, Frame_Error, Frame_Data} !== '0) begin
            failures++;
            $display("FAIL idle_outputs: got miso=%b oe=%b am=%b data=%h, expected all 0",
                     SPI_MISO, SPI_MISO_OE, Addr_Match, Frame_Data);
        end
        checks++;
        if (valid_cnt !== 0 || error_cnt !== 0) begin
            failures++;
            $display("FAIL idle_pulses: got valid=%0d error=%0d, expected 0/0", valid_cnt, error_cnt);
        end
    endtask

    task automatic test_write();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        load_tx(8'h5A, 8'h02, PAY1, 15);
        exp_q.push_back(PAY1);
        spi_frame(1'b1);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++;
            $display("FAIL write_valid_count: got %0d, expected 1", valid_cnt - v0);
        end
        checks++;
        if (Frame_Data !== PAY1) begin
            failures++;
            $display("FAIL write_data: got %h, expected %h", Frame_Data, PAY1);
        end
        checks++;
        if (error_cnt !== e0) begin
            failures++;
            $display("FAIL write_error: got %0d pulses, expected 0", error_cnt - e0);
        end
        checks++;
        if (count_ones(am_q, 0, 7) !== 0 || count_ones(am_q, 8, 135) !== 128) begin
            failures++;
            $display("FAIL write_addr_match: got %0d/%0d high in addr/rest, expected 0/128",
                     count_ones(am_q, 0, 7), count_ones(am_q, 8, 135));
        end
        checks++;
        if (count_ones(oe_q, 0, 135) !== 0) begin
            failures++;
            $display("FAIL write_oe: got %0d high samples, expected 0", count_ones(oe_q, 0, 135));
        end
        checks++;
        if (Addr_Match !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL write_end: got am=%b pending=%0d, expected 0/0", Addr_Match, exp_q.size());
        end
    endtask

    task automatic test_read();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        logic [W-1:0] got;
        logic [W-1:0] want;
        load_tx(8'h5A, 8'h03, '0, 15);
        rd_exp_q.push_back(PAY1);
        spi_frame(1'b1);
        for (int i = 0; i < W; i++) got[W-1-i] = miso_q[16+i];
        want = rd_exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL read_miso: got %h, expected %h", got, want);
        end
        checks++;
        if (count_ones(oe_q, 0, 15) !== 0 || count_ones(oe_q, 16, 135) !== 120 || oe_end !== 1'b0) begin
            failures++;
            $display("FAIL read_oe: got %0d/%0d high hdr/payload end=%b, expected 0/120 end=0",
                     count_ones(oe_q, 0, 15), count_ones(oe_q, 16, 135), oe_end);
        end
        checks++;
        if (valid_cnt !== v0 || error_cnt !== e0 || Frame_Data !== PAY1) begin
            failures++;
            $display("FAIL read_side_effects: got dv=%0d de=%0d data=%h, expected 0/0 %h",
                     valid_cnt - v0, error_cnt - e0, Frame_Data, PAY1);
        end
    endtask

    task automatic test_mismatch();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        logic [W-1:0] pay;
        pay = {8'h2F, 8'h90, 8'h09, 96'h1122_3344_5566_7788_99AA_BBCC};
        load_tx(8'h5B, 8'h02, pay, 15);
        spi_frame(1'b1);
        checks++;
        if (count_ones(am_q, 0, 135) !== 0 || count_ones(oe_q, 0, 135) !== 0) begin
            failures++;
            $display("FAIL mismatch_am_oe: got am=%0d oe=%0d high samples, expected 0/0",
                     count_ones(am_q, 0, 135), count_ones(oe_q, 0, 135));
        end
        checks++;
        if (valid_cnt !== v0 || error_cnt !== e0 || Frame_Data !== PAY1) begin
            failures++;
            $display("FAIL mismatch_effects: got dv=%0d de=%0d data=%h, expected 0/0 %h",
                     valid_cnt - v0, error_cnt - e0, Frame_Data, PAY1);
        end
    endtask

    task automatic test_errors();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        load_tx(8'h5A, 8'h07, {8'hAA, 112'h0}, 1);
        spi_frame(1'b1);
        checks++;
        if (error_cnt - e0 !== 1 || valid_cnt !== v0) begin
            failures++;
            $display("FAIL bad_cmd: got errors=%0d valids=%0d, expected 1/0",
                     error_cnt - e0, valid_cnt - v0);
        end
        e0 = error_cnt;
        load_tx(8'h5A, 8'h02, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 64'h0}, 7);
        spi_frame(1'b1);
        checks++;
        if (error_cnt - e0 !== 1 || valid_cnt !== v0) begin
            failures++;
            $display("FAIL cut_write: got errors=%0d valids=%0d, expected 1/0",
                     error_cnt - e0, valid_cnt - v0);
        end
        checks++;
        if (Frame_Data !== PAY1 || Addr_Match !== 1'b0) begin
            failures++;
            $display("FAIL cut_write_state: got data=%h am=%b, expected %h am=0",
                     Frame_Data, Addr_Match, PAY1);
        end
    endtask

    task automatic test_async_reset();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        load_tx(8'h5A, 8'h02, {40'h1234567890, 80'h0}, 5);
        spi_frame(1'b0);
        #5 nReset = 1'b0;
        #5;
        checks++;
        if ({SPI_MISO, SPI_MISO_OE, Frame_Valid, Addr_Match, Frame_Error, Frame_Data} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs: got oe=%b am=%b data=%h, expected all 0",
                     SPI_MISO_OE, Addr_Match, Frame_Data);
        end
        SPI_CS = 1'b1;
        #100 nReset = 1'b1;
        #200;
        checks++;
        if (valid_cnt !== v0 || error_cnt !== e0) begin
            failures++;
            $display("FAIL async_reset_pulses: got dv=%0d de=%0d, expected 0/0",
                     valid_cnt - v0, error_cnt - e0);
        end
        load_tx(8'h5A, 8'h02, '1, 15);
        exp_q.push_back('1);
        spi_frame(1'b1);
        checks++;
        if (valid_cnt - v0 !== 1 || Frame_Data !== {W{1'b1}}) begin
            failures++;
            $display("FAIL after_reset_write: got dv=%0d data=%h, expected 1 all-ones",
                     valid_cnt - v0, Frame_Data);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_errors();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
